// File: rtl/xor_descrambler32_pkg.sv
// Shared definitions for the 32-bit bit-serial XOR descrambler: FSM encoding,
// LFSR geometry/taps and the substitute used when a seed of zero is supplied.
package xor_descrambler32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int LFSR_W = 32;
    localparam int TAP_A  = 31;
    localparam int TAP_B  = 21;
    localparam int TAP_C  = 1;
    localparam int TAP_D  = 0;

    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 32'h0000_0001;

    // An all-zero LFSR would lock up, so zero seeds are swapped for the substitute.
    function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? ZERO_SEED_SUB : s;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D]};
    endfunction

endpackage

// File: rtl/lfsr32_step.sv
// 32-bit Fibonacci LFSR register with load (priority) and step enable.
// key_o is the keystream bit for the current cycle (the register MSB).
module lfsr32_step
    import xor_descrambler32_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 32'h0000_0001
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_val_i,
    output logic              key_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = fix_seed(load_val_i);
        end else if (en_i) begin
            lfsr_d = lfsr_advance(lfsr_q);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lfsr_q <= fix_seed(SEED);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign key_o = lfsr_q[TAP_A];

endmodule

// File: rtl/xor_module.sv
// Single-bit XOR cell shared across the descrambler datapath.
module xor_module (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = a_i ^ b_i;

endmodule

// File: rtl/xor_descrambler32.sv
// Bit-serial 32-bit XOR descrambler: IDLE accepts a word, RUN XORs one bit per
// cycle with a continuous LFSR keystream, DONE holds the result until taken.
// Optional runtime seed loading is enabled by XOR_DESCRAMBLER32_SEED_LOAD_EN.
module xor_descrambler32
    import xor_descrambler32_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
`ifdef XOR_DESCRAMBLER32_SEED_LOAD_EN
    ,
    input  logic        seed_load,
    input  logic [31:0] seed_data
`endif
);

    // Handshakes: a word moves on a rising edge where valid and ready are both 1;
    // valid/data hold until that edge, ready may depend combinationally on state.

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [31:0] res_q, res_d;
    logic        out_valid_q, out_valid_d;

    logic        accept_in;
    logic        accept_out;
    logic        lfsr_en;
    logic        seed_req;
    logic [31:0] seed_val;
    logic        key_bit;
    logic        res_bit;

`ifdef XOR_DESCRAMBLER32_SEED_LOAD_EN
    assign seed_req = seed_load && (state_q == ST_IDLE);
    assign seed_val = seed_data;
`else
    assign seed_req = 1'b0;
    assign seed_val = ZERO_SEED_SUB;
`endif

    assign accept_in  = in_valid && in_ready;
    assign accept_out = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_in)      state_d = ST_RUN;
            ST_RUN:  if (cnt_q == 5'd31) state_d = ST_DONE;
            ST_DONE: if (accept_out)     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // A seed load owns the IDLE cycle, so the word offer waits until the next one.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        lfsr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = reset_n && !seed_req;
                busy     = 1'b0;
            end
            ST_RUN:  lfsr_en = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        data_d      = data_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        if (accept_in) begin
            data_d = in_data;
            cnt_d  = '0;
        end
        if (state_q == ST_RUN) begin
            res_d[cnt_q] = res_bit;
            cnt_d        = cnt_q + 5'd1;
        end
        // out_valid is registered, so it rises one cycle after DONE is entered.
        if (state_q == ST_DONE) begin
            out_valid_d = !accept_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            data_q      <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    lfsr32_step #(
        .SEED(SEED)
    ) u_lfsr (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .en_i       (lfsr_en),
        .load_i     (seed_req),
        .load_val_i (seed_val),
        .key_o      (key_bit)
    );

    xor_module u_xor (
        .a_i (data_q[cnt_q]),
        .b_i (key_bit),
        .y_o (res_bit)
    );

    assign out_valid = out_valid_q;
    assign out_data  = res_q;

endmodule

// File: tb/tb_xor_descrambler32.sv
// Self-checking bench for xor_descrambler32 with a keystream model and an
// expected-result queue. Seed-load scenarios build with XOR_DESCRAMBLER32_SEED_LOAD_EN.
module tb_xor_descrambler32;

    localparam logic [31:0] TB_SEED = 32'h0000_0001;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
`ifdef XOR_DESCRAMBLER32_SEED_LOAD_EN
    logic        seed_load;
    logic [31:0] seed_data;
`endif

    int          n_checks;
    int          n_errors;
    int          lat_count;
    logic [31:0] exp_q[$];
    logic [31:0] m_lfsr;

    xor_descrambler32 #(
        .SEED(TB_SEED)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef XOR_DESCRAMBLER32_SEED_LOAD_EN
        ,
        .seed_load (seed_load),
        .seed_data (seed_data)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef XOR_DESCRAMBLER32_SEED_LOAD_EN
        seed_load = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_lfsr  = TB_SEED;
        exp_q.delete();
    endtask

    // Keystream model: 32 bits, LSB of the word first, each from the LFSR MSB.
    task automatic next_key(output logic [31:0] ks);
        for (int i = 0; i < 32; i++) begin
            ks[i]  = m_lfsr[31];
            m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
        end
    endtask

    // Drivers
    task automatic send_word(input logic [31:0] din, input logic [31:0] exp);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL in_ready_wait: got %b, expected 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        lat_count = 0;
        exp_q.push_back(exp);
    endtask

    task automatic recv_word(input int stall);
        logic [31:0] e;
        int          ready_seen;
        ready_seen = 0;
        while (out_valid !== 1'b1 && lat_count < 200) begin
            if (in_ready !== 1'b0) ready_seen++;
            @(posedge clk);
            #1;
            lat_count++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL out_valid_timeout: got %b, expected 1", out_valid);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        n_checks++;
        if (lat_count != 33) begin
            n_errors++;
            $display("FAIL latency: got %0d, expected 33", lat_count);
        end
        n_checks++;
        if (ready_seen != 0) begin
            n_errors++;
            $display("FAIL in_ready_busy: got %0d high cycles, expected 0", ready_seen);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            e = 'x;
        end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
                n_errors++;
                $display("FAIL out_data: got %h, expected %h", out_data, e);
            end
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_hold: got v=%b d=%h r=%b b=%b, expected v=1 d=%h r=0 b=1",
                         out_valid, out_data, in_ready, busy, e);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL release_to_idle: got b=%b r=%b v=%b, expected b=0 r=1 v=0",
                     busy, in_ready, out_valid);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef XOR_DESCRAMBLER32_SEED_LOAD_EN
        seed_load = 1'b0;
        seed_data = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%b r=%b b=%b d=%h, expected v=0 r=0 b=0 d=00000000",
                     out_valid, in_ready, busy, out_data);
        end
        reset_n = 1'b1;
        m_lfsr  = TB_SEED;
        exp_q.delete();
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle: got r=%b b=%b, expected r=1 b=0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ks;
        apply_reset();
        next_key(ks);
        send_word(32'h0000_0000, 32'h8000_0000);
        recv_word(0);
    endtask

    task automatic test_continuity();
        logic [31:0] ks;
        logic [31:0] d;
        apply_reset();
        next_key(ks);
        send_word(32'h8000_0000, 32'h0000_0000);
        recv_word(0);
        next_key(ks);
        send_word(32'h0000_0000, ks);
        recv_word(1);
        d = $urandom;
        next_key(ks);
        send_word(d, d ^ ks);
        recv_word(0);
    endtask

    task automatic test_stall();
        logic [31:0] ks;
        logic [31:0] d;
        apply_reset();
        d = $urandom;
        next_key(ks);
        send_word(d, d ^ ks);
        recv_word(100);
        d = $urandom;
        next_key(ks);
        send_word(d, d ^ ks);
        recv_word(0);
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] ks;
        int          v_seen;
        apply_reset();
        next_key(ks);
        send_word(32'h1234_5678, 32'h1234_5678 ^ ks);
        repeat (15) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_in_run: got %b, expected 1", busy);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got b=%b v=%b r=%b, expected b=0 v=0 r=0",
                     busy, out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_lfsr  = TB_SEED;
        exp_q.delete();
        v_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) v_seen++;
        end
        n_checks++;
        if (v_seen != 0) begin
            n_errors++;
            $display("FAIL discarded_word: got %0d valid cycles, expected 0", v_seen);
        end
        next_key(ks);
        send_word(32'h0000_0000, 32'h8000_0000);
        recv_word(0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, ka, kb;
        apply_reset();
        a = $urandom;
        b = $urandom;
        next_key(ka);
        next_key(kb);
        in_valid  = 1'b1;
        in_data   = a;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(a ^ ka);
        in_data   = b;
        lat_count = 0;
        out_ready = 1'b0;
        recv_word(0);
        // recv_word leaves the block in IDLE with in_valid still high: b goes in now.
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        lat_count = 0;
        exp_q.push_back(b ^ kb);
        recv_word(0);
    endtask

    task automatic test_round_trip();
        logic [31:0] w, ks;
        apply_reset();
        for (int i = 0; i < 1000; i++) begin
            w = $urandom;
            next_key(ks);
            send_word(w ^ ks, w);
            recv_word($urandom_range(0, 2));
        end
    endtask

`ifdef XOR_DESCRAMBLER32_SEED_LOAD_EN
    task automatic test_seed_load();
        logic [31:0] ks, d, s;
        apply_reset();
        next_key(ks);
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        seed_load = 1'b1;
        seed_data = 32'h0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL seed_priority: got in_ready %b, expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        in_valid  = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL seed_blocks_word: got busy %b, expected 0", busy);
        end
        m_lfsr = 32'h0000_0001;
        next_key(ks);
        send_word(32'h0000_0000, 32'h8000_0000);
        recv_word(0);
        s = $urandom | 32'h1;
        seed_load = 1'b1;
        seed_data = s;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        m_lfsr    = s;
        d = $urandom;
        next_key(ks);
        send_word(d, d ^ ks);
        for (int i = 0; i < 10; i++) begin
            seed_load = 1'b1;
            seed_data = $urandom;
            @(posedge clk);
            #1;
            lat_count++;
        end
        seed_load = 1'b0;
        recv_word(0);
        d = $urandom;
        next_key(ks);
        send_word(d, d ^ ks);
        recv_word(0);
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_continuity();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
`ifdef XOR_DESCRAMBLER32_SEED_LOAD_EN
        test_seed_load();
`endif
        test_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/xor_descrambler32.md
XOR_DESCRAMBLER32 -- requirements
Module: xor_descrambler32

Interface
REQ-001 SHALL have parameter SEED, default 32'h0000_0001: LFSR value loaded at reset; a zero value is replaced by 32'h0000_0001.
REQ-002 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, in_data holds a scrambled word.
REQ-005 SHALL have port in_ready, output, 1, block can accept a word.
REQ-006 SHALL have port in_data, input, 32, scrambled word.
REQ-007 SHALL have port out_valid, output, 1, out_data holds a descrambled word.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts out_data.
REQ-009 SHALL have port out_data, output, 32, descrambled word.
REQ-010 SHALL have port busy, output, 1, FSM is not in IDLE.
REQ-011 SHALL have ports seed_load (input, 1) and seed_data (input, 32), present only when the configuration macro is defined.

Function
REQ-012 FSM states SHALL be IDLE, RUN, and DONE.
REQ-013 IDLE SHALL assert in_ready; when in_valid=1, the block SHALL latch in_data, clear the bit counter, and go to RUN.
REQ-014 RUN SHALL process one bit per cycle, LSB first: result[i] = data[i] XOR lfsr[31].
REQ-015 In RUN, the LFSR SHALL advance every cycle: lfsr <= {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
REQ-016 After bit 31 (exactly 32 RUN cycles), RUN SHALL go to DONE.
REQ-017 DONE SHALL assert out_valid with stable out_data, and SHALL hold both until out_ready=1, then go to IDLE.
REQ-018 Latency SHALL be 33 cycles from the in_valid/in_ready handshake to the first out_valid.
REQ-019 Throughput SHALL be one word per 34 cycles or more; in_ready SHALL be 0 in RUN and DONE.
REQ-020 LFSR state SHALL carry across words (keystream is continuous) and SHALL advance only in RUN.
REQ-021 out_ready=0 in DONE SHALL stall indefinitely without data loss or LFSR advance.
REQ-022 in_valid asserted in RUN or DONE SHALL be ignored; it SHALL be accepted once the block is back in IDLE.

Reset
REQ-023 On reset_n=0, asynchronously: state=IDLE, lfsr=SEED (zero mapped to 1), counter=0, out_data=0, out_valid=0, in_ready=0 while asserted, busy=0.
REQ-024 Reset mid-RUN or mid-DONE SHALL discard the word in flight; no out_valid SHALL follow.
REQ-025 The first cycle after deassertion SHALL be IDLE with in_ready=1.

Configuration
REQ-026 Macro XOR_DESCRAMBLER32_SEED_LOAD_EN SHALL control runtime seed loading.
REQ-027 With the macro: seed_load=1 in IDLE SHALL set lfsr=seed_data (zero mapped to 1) and SHALL take priority over in_valid that cycle (in_ready=0 that cycle); seed_load outside IDLE SHALL be ignored.
REQ-028 Without the macro: seed_load and seed_data SHALL be absent, and the LFSR SHALL be re-seeded only by reset.

Structure
REQ-029 A shared package SHALL hold: the FSM state encoding (IDLE/RUN/DONE), LFSR width 32, tap constants 31/21/1/0, and the zero-seed substitute 32'h0000_0001.
REQ-030 One sub-module, lfsr32_step, SHALL hold the LFSR register with enable and load; it SHALL be instantiated once.
REQ-031 The bit XOR SHALL reuse the existing single-bit xor_module.

Verification
REQ-032 SEED=1, reset, in_data=32'h0000_0000 -> out_data=32'h8000_0000, out_valid exactly 33 cycles after the handshake.
REQ-033 SEED=1, in_data=32'h8000_0000 -> out_data=32'h0000_0000; the next word 32'h0 -> out_data matches the bit-accurate model, continuing from lfsr after 32 steps.
REQ-034 Hold out_ready=0 for 100 cycles in DONE -> out_valid and out_data stable, in_ready=0, LFSR unchanged; release -> IDLE next cycle.
REQ-035 Assert reset_n=0 at RUN bit 15 -> out_valid never rises; the next word 32'h0 after reset yields 32'h8000_0000 (SEED=1).
REQ-036 With the macro: seed_load=1 with seed_data=0 in IDLE, then in_data=0 -> 32'h8000_0000; seed_load during RUN -> no effect.
REQ-037 Round trip: 1000 random words scrambled by the model with the same seed -> every out_data equals the original word.
